priority_mask_scanner: RTL and testbench

- Sequential successor to the combinational priority encoder.
- Accepts a DATAW-bit mask with an optional tag, then emits the index of every set bit, one index per cycle, in priority order.
- Priority order is LSB-first or MSB-first, selected by parameter.
- Used for thread/lane-mask iteration, e.g. serialising per-lane requests.
- Valid/ready on both sides; back-to-back masks with no bubble.

---
 rtl/priority_mask_scanner_if.sv | 29 ++
 rtl/priority_mask_scanner.sv | 117 +++++++++++
 tb/tb_priority_mask_scanner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_mask_scanner_if.sv
// Mask-in / index-out handshake bundle for priority_mask_scanner.
// slave is the scanner side; master is the producer/consumer side.
`timescale 1ns/1ps
interface priority_mask_scanner_if #(
   parameter int unsigned DATAW  = 8,
   parameter int unsigned TAGW   = 1,
   parameter int unsigned LDATAW = (DATAW > 1) ? $clog2(DATAW) : 1
);
   logic              valid_in;
   logic [DATAW-1:0]  data_in;
   logic [TAGW-1:0]   tag_in;
   logic              ready_in;
   logic              valid_out;
   logic [LDATAW-1:0] index_out;
   logic [TAGW-1:0]   tag_out;
   logic              last_out;
   logic              empty_out;
   logic              ready_out;

   modport slave (
      input  valid_in, data_in, tag_in, ready_out,
      output ready_in, valid_out, index_out, tag_out, last_out, empty_out
   );

   modport master (
      output valid_in, data_in, tag_in, ready_out,
      input  ready_in, valid_out, index_out, tag_out, last_out, empty_out
   );
endinterface

// File: rtl/priority_mask_scanner.sv
// Serialises a bit mask into one index beat per set bit, in LSB- or MSB-first
// priority order, with valid/ready on both sides and no bubble between masks.
`timescale 1ns/1ps
module priority_mask_scanner #(
   parameter int unsigned DATAW   = 8,
   parameter bit          REVERSE = 1'b0,
   parameter int unsigned TAGW    = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   priority_mask_scanner_if.slave bus
);
   localparam int unsigned LDATAW = (DATAW > 1) ? $clog2(DATAW) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SCAN = 1'b1;

   logic [0:0]        state, state_nxt;
   logic [DATAW-1:0]  remaining, remaining_nxt;
   logic [TAGW-1:0]   tag_r, tag_nxt;
   logic              empty_r, empty_nxt;
   logic [LDATAW-1:0] index_r, index_nxt;
   logic              last_r, last_nxt;
   logic              ready_c, accept_c, fire_c;

   // Highest-priority set bit; later matches overwrite earlier ones.
   function automatic logic [LDATAW-1:0] find_first(input logic [DATAW-1:0] m);
      logic [LDATAW-1:0] idx;
      idx = '0;
      if (REVERSE) begin
         for (int i = 0; i < int'(DATAW); i++)
            if (m[i]) idx = LDATAW'(i);
      end else begin
         for (int i = int'(DATAW) - 1; i >= 0; i--)
            if (m[i]) idx = LDATAW'(i);
      end
      return idx;
   endfunction

   function automatic logic [DATAW-1:0] clear_bit(input logic [DATAW-1:0] m,
                                                  input logic [LDATAW-1:0] idx);
      logic [DATAW-1:0] r;
      r = m;
      for (int i = 0; i < int'(DATAW); i++)
         if (LDATAW'(i) == idx) r[i] = 1'b0;
      return r;
   endfunction

   function automatic logic at_most_one(input logic [DATAW-1:0] m);
      return (m & (m - DATAW'(1))) == '0;
   endfunction

   assign fire_c   = (state == S_SCAN) & bus.ready_out;
   assign ready_c  = reset_n & ((state == S_IDLE) | (fire_c & last_r));
   assign accept_c = bus.valid_in & ready_c;

   // Next-state and next-beat computation; index/last are pre-computed so
   // every beat output comes straight from a flop.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      tag_nxt       = tag_r;
      empty_nxt     = empty_r;
      case (state)
         S_IDLE: begin
            if (accept_c) begin
               remaining_nxt = bus.data_in;
               tag_nxt       = bus.tag_in;
               empty_nxt     = (bus.data_in == '0);
               state_nxt     = S_SCAN;
            end
         end
         S_SCAN: begin
            if (fire_c) begin
               if (!last_r) begin
                  remaining_nxt = clear_bit(remaining, index_r);
               end else if (accept_c) begin
                  remaining_nxt = bus.data_in;
                  tag_nxt       = bus.tag_in;
                  empty_nxt     = (bus.data_in == '0);
               end else begin
                  remaining_nxt = '0;
                  state_nxt     = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      index_nxt = find_first(remaining_nxt);
      last_nxt  = (state_nxt == S_SCAN) & at_most_one(remaining_nxt);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         remaining <= '0;
         tag_r     <= '0;
         empty_r   <= 1'b0;
         index_r   <= '0;
         last_r    <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         tag_r     <= tag_nxt;
         empty_r   <= empty_nxt;
         index_r   <= index_nxt;
         last_r    <= last_nxt;
      end
   end

   assign bus.ready_in  = ready_c;
   assign bus.valid_out = (state == S_SCAN);
   assign bus.index_out = index_r;
   assign bus.tag_out   = tag_r;
   assign bus.last_out  = last_r;
   assign bus.empty_out = empty_r;
endmodule

// File: tb/tb_priority_mask_scanner.sv
// Directed bench for priority_mask_scanner: LSB/MSB order, empty mask,
// backpressure, back-to-back masks, mid-scan reset and DATAW=1.
`timescale 1ns/1ps
module tb_priority_mask_scanner;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   priority_mask_scanner_if #(.DATAW(8), .TAGW(1)) if_f ();
   priority_mask_scanner_if #(.DATAW(8), .TAGW(1)) if_r ();
   priority_mask_scanner_if #(.DATAW(1), .TAGW(1)) if_1 ();

   priority_mask_scanner #(.DATAW(8), .REVERSE(1'b0), .TAGW(1)) u_fwd (
      .clk(clk), .reset_n(reset_n), .bus(if_f.slave));
   priority_mask_scanner #(.DATAW(8), .REVERSE(1'b1), .TAGW(1)) u_rev (
      .clk(clk), .reset_n(reset_n), .bus(if_r.slave));
   priority_mask_scanner #(.DATAW(1), .REVERSE(1'b0), .TAGW(1)) u_one (
      .clk(clk), .reset_n(reset_n), .bus(if_1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      total++;
      if (if_f.valid_out !== 1'b0 || if_f.index_out !== 3'd0 || if_f.tag_out !== 1'b0 ||
          if_f.last_out !== 1'b0 || if_f.empty_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b i=%0d t=%b l=%b e=%b exp all 0",
                  if_f.valid_out, if_f.index_out, if_f.tag_out, if_f.last_out, if_f.empty_out);
      end
      total++;
      if (if_f.ready_in !== 1'b0 || if_r.ready_in !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_in got %b/%b exp 0/0", if_f.ready_in, if_r.ready_in);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if (if_f.ready_in !== 1'b1 || if_f.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", if_f.ready_in, if_f.valid_out);
      end
   endtask

   task automatic test_lsb_first();
      logic [2:0] exp_idx [4] = '{3'd1, 3'd4, 3'd5, 3'd7};
      if_f.valid_in = 1'b1; if_f.data_in = 8'hB2; if_f.tag_in = 1'b1;
      tick();
      if_f.valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (if_f.valid_out !== 1'b1 || if_f.index_out !== exp_idx[k] ||
             if_f.last_out !== (k == 3) || if_f.tag_out !== 1'b1 || if_f.empty_out !== 1'b0) begin
            bad++;
            $display("FAIL lsb_beat%0d got v=%b i=%0d l=%b t=%b e=%b exp v=1 i=%0d l=%b t=1 e=0",
                     k, if_f.valid_out, if_f.index_out, if_f.last_out, if_f.tag_out,
                     if_f.empty_out, exp_idx[k], (k == 3));
         end
         tick();
      end
      total++;
      if (if_f.valid_out !== 1'b0 || if_f.ready_in !== 1'b1) begin
         bad++;
         $display("FAIL lsb_done got v=%b rdy=%b exp v=0 rdy=1", if_f.valid_out, if_f.ready_in);
      end
   endtask

   task automatic test_msb_first();
      logic [2:0] exp_idx [4] = '{3'd7, 3'd5, 3'd4, 3'd1};
      if_r.valid_in = 1'b1; if_r.data_in = 8'hB2; if_r.tag_in = 1'b1;
      tick();
      if_r.valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (if_r.valid_out !== 1'b1 || if_r.index_out !== exp_idx[k] ||
             if_r.last_out !== (k == 3) || if_r.ready_in !== (k == 3)) begin
            bad++;
            $display("FAIL msb_beat%0d got v=%b i=%0d l=%b rdy=%b exp v=1 i=%0d l=%b rdy=%b",
                     k, if_r.valid_out, if_r.index_out, if_r.last_out, if_r.ready_in,
                     exp_idx[k], (k == 3), (k == 3));
         end
         tick();
      end
      total++;
      if (if_r.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL msb_done got v=%b exp 0", if_r.valid_out);
      end
   endtask

   task automatic test_zero_mask();
      if_f.valid_in = 1'b1; if_f.data_in = 8'h00; if_f.tag_in = 1'b0;
      tick();
      if_f.valid_in = 1'b0;
      total++;
      if (if_f.valid_out !== 1'b1 || if_f.index_out !== 3'd0 || if_f.empty_out !== 1'b1 ||
          if_f.last_out !== 1'b1 || if_f.ready_in !== 1'b1) begin
         bad++;
         $display("FAIL zero_beat got v=%b i=%0d e=%b l=%b rdy=%b exp v=1 i=0 e=1 l=1 rdy=1",
                  if_f.valid_out, if_f.index_out, if_f.empty_out, if_f.last_out, if_f.ready_in);
      end
      tick();
      total++;
      if (if_f.valid_out !== 1'b0 || if_f.ready_in !== 1'b1) begin
         bad++;
         $display("FAIL zero_done got v=%b rdy=%b exp v=0 rdy=1", if_f.valid_out, if_f.ready_in);
      end
   endtask

   task automatic test_backpressure();
      if_f.valid_in = 1'b1; if_f.data_in = 8'h81; if_f.tag_in = 1'b0;
      tick();
      if_f.valid_in = 1'b0;
      if_f.ready_out = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) if_f.ready_out = 1'b1;
         total++;
         if (if_f.valid_out !== 1'b1 || if_f.index_out !== 3'd0 || if_f.last_out !== 1'b0 ||
             if_f.ready_in !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d got v=%b i=%0d l=%b rdy=%b exp v=1 i=0 l=0 rdy=0",
                     k, if_f.valid_out, if_f.index_out, if_f.last_out, if_f.ready_in);
         end
         tick();
      end
      total++;
      if (if_f.valid_out !== 1'b1 || if_f.index_out !== 3'd7 || if_f.last_out !== 1'b1) begin
         bad++;
         $display("FAIL stall_second got v=%b i=%0d l=%b exp v=1 i=7 l=1",
                  if_f.valid_out, if_f.index_out, if_f.last_out);
      end
      tick();
      total++;
      if (if_f.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL stall_done got v=%b exp 0", if_f.valid_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_idx [3] = '{3'd1, 3'd2, 3'd3};
      logic       exp_tag [3] = '{1'b0, 1'b0, 1'b1};
      logic       exp_last[3] = '{1'b0, 1'b1, 1'b1};
      if_f.valid_in = 1'b1; if_f.data_in = 8'h06; if_f.tag_in = 1'b0;
      tick();
      if_f.valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            if_f.valid_in = 1'b1; if_f.data_in = 8'h08; if_f.tag_in = 1'b1;
            #1;
            total++;
            if (if_f.ready_in !== 1'b1) begin
               bad++;
               $display("FAIL b2b_ready got %b exp 1", if_f.ready_in);
            end
         end
         if (k == 2) if_f.valid_in = 1'b0;
         total++;
         if (if_f.valid_out !== 1'b1 || if_f.index_out !== exp_idx[k] ||
             if_f.tag_out !== exp_tag[k] || if_f.last_out !== exp_last[k]) begin
            bad++;
            $display("FAIL b2b_beat%0d got v=%b i=%0d t=%b l=%b exp v=1 i=%0d t=%b l=%b",
                     k, if_f.valid_out, if_f.index_out, if_f.tag_out, if_f.last_out,
                     exp_idx[k], exp_tag[k], exp_last[k]);
         end
         tick();
      end
      total++;
      if (if_f.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done got v=%b exp 0", if_f.valid_out);
      end
   endtask

   task automatic test_reset_mid_scan();
      if_f.valid_in = 1'b1; if_f.data_in = 8'hFF; if_f.tag_in = 1'b1;
      tick();
      if_f.valid_in = 1'b0;
      tick();
      tick();
      total++;
      if (if_f.valid_out !== 1'b1 || if_f.index_out !== 3'd2) begin
         bad++;
         $display("FAIL rst_third_beat got v=%b i=%0d exp v=1 i=2", if_f.valid_out, if_f.index_out);
      end
      reset_n = 1'b0;
      tick();
      total++;
      if (if_f.valid_out !== 1'b0 || if_f.ready_in !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid got v=%b rdy=%b exp v=0 rdy=0", if_f.valid_out, if_f.ready_in);
      end
      reset_n = 1'b1;
      #1;
      total++;
      if (if_f.ready_in !== 1'b1) begin
         bad++;
         $display("FAIL rst_release got rdy=%b exp 1", if_f.ready_in);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (if_f.valid_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_residual%0d got v=%b exp 0", k, if_f.valid_out);
         end
      end
   endtask

   task automatic test_dataw1();
      if_1.valid_in = 1'b1; if_1.data_in = 1'b1; if_1.tag_in = 1'b1;
      tick();
      if_1.valid_in = 1'b1; if_1.data_in = 1'b0; if_1.tag_in = 1'b0;
      total++;
      if (if_1.valid_out !== 1'b1 || if_1.index_out !== 1'b0 || if_1.last_out !== 1'b1 ||
          if_1.empty_out !== 1'b0 || if_1.tag_out !== 1'b1) begin
         bad++;
         $display("FAIL w1_one got v=%b i=%0d l=%b e=%b t=%b exp v=1 i=0 l=1 e=0 t=1",
                  if_1.valid_out, if_1.index_out, if_1.last_out, if_1.empty_out, if_1.tag_out);
      end
      tick();
      if_1.valid_in = 1'b0;
      total++;
      if (if_1.valid_out !== 1'b1 || if_1.index_out !== 1'b0 || if_1.last_out !== 1'b1 ||
          if_1.empty_out !== 1'b1) begin
         bad++;
         $display("FAIL w1_zero got v=%b i=%0d l=%b e=%b exp v=1 i=0 l=1 e=1",
                  if_1.valid_out, if_1.index_out, if_1.last_out, if_1.empty_out);
      end
      tick();
      total++;
      if (if_1.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL w1_done got v=%b exp 0", if_1.valid_out);
      end
   endtask

   initial begin
      if_f.valid_in = 1'b0; if_f.data_in = '0; if_f.tag_in = '0; if_f.ready_out = 1'b1;
      if_r.valid_in = 1'b0; if_r.data_in = '0; if_r.tag_in = '0; if_r.ready_out = 1'b1;
      if_1.valid_in = 1'b0; if_1.data_in = '0; if_1.tag_in = '0; if_1.ready_out = 1'b1;
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_zero_mask();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_scan();
      test_dataw1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
